// File: rtl/ram_loader.sv
// ram_loader: framed LEN/data/CSUM stream loader for the data RAM, CPU pass-through when idle
module ram_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);
  typedef enum logic [2:0] {IDLE, S_LEN, S_DATA, S_CSUM, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0] len;
  logic [DATA_W-1:0] sum;
  logic [DATA_W:0] len_in;
  logic xfer, len_bad, idle_start;
  assign busy = state == S_LEN || state == S_DATA || state == S_CSUM;
  assign in_ready = busy;
  assign xfer = in_valid && in_ready;
  assign len_in = in_data == '0 ? (DATA_W+1)'(DEPTH) : {1'b0, in_data};
  assign len_bad = len_in > (DATA_W+1)'(DEPTH);
  assign idle_start = (state == IDLE || state == DONE) && start;
  assign ram_we = busy ? state == S_DATA && xfer : cpu_we;
  assign ram_addr = busy ? addr : cpu_addr;
  assign ram_wdata = busy ? in_data : cpu_wdata;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: state_n = start ? S_LEN : state;
      S_LEN:      state_n = xfer ? (len_bad ? DONE : S_DATA) : state;
      S_DATA:     state_n = xfer && count + (ADDR_W+1)'(1) == len ? S_CSUM : state;
      S_CSUM:     state_n = xfer ? DONE : state;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      len   <= '0;
      sum   <= '0;
      count <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (idle_start) begin
        addr  <= '0;
        sum   <= '0;
        count <= '0;
        done  <= 1'b0;
        err   <= 1'b0;
      end
      if (state == S_LEN && xfer) begin
        if (len_bad) begin
          err  <= 1'b1;
          done <= 1'b1;
        end else len <= len_in[ADDR_W:0];
      end
      if (state == S_DATA && xfer) begin
        addr  <= addr + ADDR_W'(1);
        count <= count + (ADDR_W+1)'(1);
        sum   <= sum + in_data;
      end
      if (state == S_CSUM && xfer) begin
        err  <= in_data != sum;
        done <= 1'b1;
      end
    end
  end
endmodule
